pipe_ex_stage: RTL and testbench
================================

Name: pipe_ex_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS-subset CPU.
- Contains the ID/EX pipeline register, which captures decoded operands and controls from the decode stage on each clock edge.
- Drives a combinational ALU, branch-target adder, zero flag and destination-register select from that register.
- The memory stage's EX/MEM register consumes these results.
- Also forwards the instruction tag (type/number) used by the debug display.

Parameters:
- DW, 32, datapath width (fixed 32 for this ISA; a parameter only for readability).
- RW, 5, register-index width.

Ports:
- clk  in  1  pipeline step clock (debounced single-step button in the system); all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_imm  in  32  extended immediate from ID; bits [10:6] carry shamt.
- id_inA  in  32  rs operand.
- id_inB  in  32  rt operand.
- id_wreg  in  1  register-write enable.
- id_m2reg  in  1  writeback selects memory data.
- id_wmem  in  1  memory write enable.
- id_aluc  in  4  ALU operation code.
- id_aluimm  in  1  ALU B operand = immediate.
- id_shift  in  1  ALU A operand = shamt.
- id_branch  in  1  conditional branch (beq) instruction.
- id_pc4  in  32  PC+4 of the instruction.
- id_regrt  in  1  destination is rt (1) or rd (0).
- id_rt  in  5  rt index.
- id_rd  in  5  rd index.
- ex_wreg, ex_m2reg, ex_wmem, ex_branch  out  1 each  registered controls.
- ex_aluR  out  32  ALU result.
- ex_inB  out  32  registered rt operand (store data).
- ex_destR  out  5  destination register index.
- ex_pc  out  32  branch target.
- ex_zero  out  1  ALU result equals zero.
- EX_ins_type, EX_ins_number  in  4 each  tag of the instruction entering EX.
- MEM_ins_type, MEM_ins_number  out  4 each  registered tag.

Behaviour:
- ID/EX register: on rising clk, all id_* inputs and the EX_ins_* tags are captured. No enable input; stalls reach this stage as bubbles (ID drives wreg = wmem = branch = 0).
- Reset (rst = 0, asynchronous) clears every register bit to 0. While reset is held, all outputs therefore read:
  - ex_aluR = 0 (add 0+0), ex_zero = 1, ex_destR = 0, ex_pc = 0.
  - All controls and tags = 0.
- Release of reset takes effect on the next rising edge.
- Outputs are combinational from the register contents only. Latency: one clk edge from ID inputs to valid ex_* outputs. No combinational path from id_* to ex_*.
- Operand A = shift ? {27'b0, imm_r[10:6]} : inA_r.
- Operand B = aluimm ? imm_r : inB_r.
- aluc encoding (unlisted codes produce 0):
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 nor
  - 0110 slt (signed, result 1/0)
  - 0111 sll (B << A[4:0])
  - 1000 srl
  - 1001 sra
  - 1010 lui ({B[15:0], 16'b0})
- Add and sub wrap modulo 2^32; no flags except ex_zero.
- ex_zero = (ex_aluR == 0).
- ex_pc = pc4_r + (imm_r << 2), computed modulo 2^32 regardless of branch.
- ex_destR = regrt_r ? rt_r : rd_r.
- ex_inB = inB_r.
- Controls pass through unchanged, except as modified under the optional feature.
- MEM_ins_type / MEM_ins_number = registered tags.

Optional Feature:
- EX_OVF_EN defined:
  - Adds output ex_ovf (1 bit) = signed overflow of add/sub.
  - When ex_ovf = 1, ex_wreg is forced to 0 so the result is not written back.
- EX_OVF_EN undefined:
  - No ex_ovf port.
  - Arithmetic wraps silently and wreg passes through.

Decomposition:
- Shared package cpu_pkg holds the aluc localparams (ALU_ADD … ALU_LUI) and the width constants; the ID stage uses the same package.
- One natural sub-module: ex_alu (operands A, B and aluc in; result, zero and optional ovf out; purely combinational).

Test Plan:
- Reset: hold rst = 0 with nonzero id_* inputs, then pulse clk -> outputs stay 0, ex_zero = 1; deassert rst, clk -> inputs appear.
- R-type add: inA = 5, inB = 7, aluc = 0000, regrt = 0, rd = 9, wreg = 1, clk -> ex_aluR = 12, ex_destR = 9, ex_wreg = 1, ex_zero = 0.
- Immediate/shift:
  - aluimm = 1, imm = 0xFFFFFFFC, inA = 4, add -> ex_aluR = 0, ex_zero = 1.
  - shift = 1, imm[10:6] = 4, inB = 0x80000000, sra -> 0xF8000000.
  - srl -> 0x08000000.
- Branch: pc4 = 0x10, imm = 0xFFFFFFFE, branch = 1, inA = inB = 3, sub -> ex_pc = 0x08, ex_zero = 1, ex_branch = 1.
- Store/regrt/slt:
  - wmem = 1, inB = 0xDEADBEEF, regrt = 1, rt = 3 -> ex_inB = 0xDEADBEEF, ex_destR = 3.
  - slt with A = -1, B = 1 -> ex_aluR = 1.
- Tags and bubble: EX_ins_type = 3, EX_ins_number = 7 -> MEM_ins_* = 3/7 after the edge; all-zero control inputs produce zero controls.
- With EX_OVF_EN: add of 0x7FFFFFFF and 1 -> ex_ovf = 1, ex_wreg = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, datapath widths and the ID/EX register layout
package cpu_pkg;
    localparam int CPU_DW = 32;
    localparam int CPU_RW = 5;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    typedef struct packed {
        logic [CPU_DW-1:0] imm;
        logic [CPU_DW-1:0] ina;
        logic [CPU_DW-1:0] inb;
        logic [CPU_DW-1:0] pc4;
        logic [3:0]        aluc;
        logic [CPU_RW-1:0] rt;
        logic [CPU_RW-1:0] rd;
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic              shift;
        logic              branch;
        logic              regrt;
        logic [3:0]        itype;
        logic [3:0]        inum;
    } idex_t;
endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational execute ALU with zero flag; signed add/sub overflow output when EX_OVF_EN is defined
module ex_alu
    import cpu_pkg::*;
(
    input  logic [CPU_DW-1:0] a,
    input  logic [CPU_DW-1:0] b,
    input  logic [3:0]        aluc,
    output logic [CPU_DW-1:0] r,
    output logic              zero
`ifdef EX_OVF_EN
    ,
    output logic              ovf
`endif
);
    logic [CPU_DW-1:0] sum, diff;
    assign sum  = a + b;
    assign diff = a - b;

    // result select by opcode; unlisted codes give zero
    always_comb begin
        case (aluc)
            ALU_ADD: r = sum;
            ALU_SUB: r = diff;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = {{(CPU_DW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLL: r = b << a[4:0];
            ALU_SRL: r = b >> a[4:0];
            ALU_SRA: r = $signed(b) >>> a[4:0];
            ALU_LUI: r = {b[15:0], 16'b0};
            default: r = '0;
        endcase
    end

    assign zero = (r == '0);

`ifdef EX_OVF_EN
    assign ovf = (aluc == ALU_ADD && a[CPU_DW-1] == b[CPU_DW-1] && sum[CPU_DW-1] != a[CPU_DW-1])
              || (aluc == ALU_SUB && a[CPU_DW-1] != b[CPU_DW-1] && diff[CPU_DW-1] != a[CPU_DW-1]);
`endif
endmodule

// File: rtl/pipe_ex_stage.sv
// pipe_ex_stage: ID/EX register feeding ALU, branch-target adder and dest select; EX_OVF_EN adds ex_ovf and suppresses wreg on overflow
module pipe_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int RW = CPU_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_inA,
    input  logic [DW-1:0] id_inB,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          id_wmem,
    input  logic [3:0]    id_aluc,
    input  logic          id_aluimm,
    input  logic          id_shift,
    input  logic          id_branch,
    input  logic [DW-1:0] id_pc4,
    input  logic          id_regrt,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [3:0]    EX_ins_type,
    input  logic [3:0]    EX_ins_number,
    output logic          ex_wreg,
    output logic          ex_m2reg,
    output logic          ex_wmem,
    output logic          ex_branch,
    output logic [DW-1:0] ex_aluR,
    output logic [DW-1:0] ex_inB,
    output logic [RW-1:0] ex_destR,
    output logic [DW-1:0] ex_pc,
    output logic          ex_zero,
`ifdef EX_OVF_EN
    output logic          ex_ovf,
`endif
    output logic [3:0]    MEM_ins_type,
    output logic [3:0]    MEM_ins_number
);
    idex_t q;
    logic [DW-1:0] op_a, op_b;

    // ID/EX register: captures everything each edge, cleared by async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else
            q <= '{imm: id_imm, ina: id_inA, inb: id_inB, pc4: id_pc4, aluc: id_aluc,
                   rt: id_rt, rd: id_rd, wreg: id_wreg, m2reg: id_m2reg, wmem: id_wmem,
                   aluimm: id_aluimm, shift: id_shift, branch: id_branch, regrt: id_regrt,
                   itype: EX_ins_type, inum: EX_ins_number};
    end

    assign op_a = q.shift ? {{(DW-5){1'b0}}, q.imm[10:6]} : q.ina;
    assign op_b = q.aluimm ? q.imm : q.inb;

`ifdef EX_OVF_EN
    logic ovf;
    ex_alu u_alu (.a(op_a), .b(op_b), .aluc(q.aluc), .r(ex_aluR), .zero(ex_zero), .ovf(ovf));
    assign ex_ovf  = ovf;
    assign ex_wreg = q.wreg & ~ovf;
`else
    ex_alu u_alu (.a(op_a), .b(op_b), .aluc(q.aluc), .r(ex_aluR), .zero(ex_zero));
    assign ex_wreg = q.wreg;
`endif

    assign ex_m2reg       = q.m2reg;
    assign ex_wmem        = q.wmem;
    assign ex_branch      = q.branch;
    assign ex_inB         = q.inb;
    assign ex_destR       = q.regrt ? q.rt : q.rd;
    assign ex_pc          = q.pc4 + {q.imm[DW-3:0], 2'b00};
    assign MEM_ins_type   = q.itype;
    assign MEM_ins_number = q.inum;
endmodule

// File: tb/tb_pipe_ex_stage.sv
// tb_pipe_ex_stage: table-driven directed checks of pipe_ex_stage; EX_OVF_EN selects the overflow checks
module tb_pipe_ex_stage;
    logic        clk = 0, rst = 0;
    logic [31:0] id_imm, id_inA, id_inB, id_pc4;
    logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch, id_regrt;
    logic [3:0]  id_aluc, EX_ins_type, EX_ins_number;
    logic [4:0]  id_rt, id_rd;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
    logic [31:0] ex_aluR, ex_inB, ex_pc;
    logic [4:0]  ex_destR;
    logic [3:0]  MEM_ins_type, MEM_ins_number;
`ifdef EX_OVF_EN
    logic        ex_ovf;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pipe_ex_stage dut (
        .clk(clk), .rst(rst), .id_imm(id_imm), .id_inA(id_inA), .id_inB(id_inB),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluc(id_aluc),
        .id_aluimm(id_aluimm), .id_shift(id_shift), .id_branch(id_branch), .id_pc4(id_pc4),
        .id_regrt(id_regrt), .id_rt(id_rt), .id_rd(id_rd),
        .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_branch(ex_branch),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR), .ex_pc(ex_pc),
        .ex_zero(ex_zero),
`ifdef EX_OVF_EN
        .ex_ovf(ex_ovf),
`endif
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
    );

    typedef struct {
        logic [3:0]  aluc;
        logic        aluimm, shift, regrt;
        logic [3:0]  ctl;
        logic [31:0] ina, inb, imm, pc4;
        logic [4:0]  rt, rd;
        logic [3:0]  ityp, inum;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [4:0]  e_dest;
        logic [31:0] e_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_aluc = v.aluc; id_aluimm = v.aluimm; id_shift = v.shift; id_regrt = v.regrt;
        {id_wreg, id_m2reg, id_wmem, id_branch} = v.ctl;
        id_inA = v.ina; id_inB = v.inb; id_imm = v.imm; id_pc4 = v.pc4;
        id_rt = v.rt; id_rd = v.rd; EX_ins_type = v.ityp; EX_ins_number = v.inum;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];
    vec_t v;

    initial begin
        tbl[0]  = '{4'h0, 0, 0, 0, 4'b1000, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 5'd9, 4'd1, 4'd1, 32'd12, 0, 5'd9, 32'd0};
        tbl[1]  = '{4'h0, 1, 0, 1, 4'b1000, 32'd4, 32'd0, 32'hFFFFFFFC, 32'd0, 5'd2, 5'd0, 4'd1, 4'd2, 32'd0, 1, 5'd2, 32'hFFFFFFF0};
        tbl[2]  = '{4'h9, 0, 1, 0, 4'b1000, 32'd0, 32'h80000000, 32'h100, 32'd0, 5'd0, 5'd5, 4'd1, 4'd3, 32'hF8000000, 0, 5'd5, 32'h400};
        tbl[3]  = '{4'h8, 0, 1, 0, 4'b1000, 32'd0, 32'h80000000, 32'h100, 32'd0, 5'd0, 5'd5, 4'd1, 4'd4, 32'h08000000, 0, 5'd5, 32'h400};
        tbl[4]  = '{4'h1, 0, 0, 0, 4'b0001, 32'd3, 32'd3, 32'hFFFFFFFE, 32'h10, 5'd0, 5'd0, 4'd2, 4'd5, 32'd0, 1, 5'd0, 32'h8};
        tbl[5]  = '{4'h0, 1, 0, 1, 4'b0010, 32'h100, 32'hDEADBEEF, 32'd8, 32'd0, 5'd3, 5'd0, 4'd4, 4'd6, 32'h108, 0, 5'd3, 32'h20};
        tbl[6]  = '{4'h6, 0, 0, 0, 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd10, 4'd1, 4'd7, 32'd1, 0, 5'd10, 32'd0};
        tbl[7]  = '{4'h6, 0, 0, 0, 4'b1000, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd10, 4'd1, 4'd8, 32'd0, 1, 5'd10, 32'd0};
        tbl[8]  = '{4'h2, 0, 0, 0, 4'b1000, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd0, 5'd11, 4'd1, 4'd9, 32'hF000, 0, 5'd11, 32'd0};
        tbl[9]  = '{4'h3, 0, 0, 0, 4'b1000, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd0, 5'd11, 4'd1, 4'd10, 32'hFFF0, 0, 5'd11, 32'd0};
        tbl[10] = '{4'h4, 0, 0, 0, 4'b1000, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd0, 5'd11, 4'd1, 4'd11, 32'h0FF0, 0, 5'd11, 32'd0};
        tbl[11] = '{4'h5, 0, 0, 0, 4'b1000, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd0, 5'd11, 4'd1, 4'd12, 32'hFFFF000F, 0, 5'd11, 32'd0};
        tbl[12] = '{4'h7, 0, 1, 0, 4'b1000, 32'd0, 32'd1, 32'h100, 32'd0, 5'd0, 5'd12, 4'd1, 4'd13, 32'h10, 0, 5'd12, 32'h400};
        tbl[13] = '{4'hA, 1, 0, 1, 4'b1100, 32'd0, 32'd0, 32'h1234, 32'd0, 5'd31, 5'd0, 4'd5, 4'd14, 32'h12340000, 0, 5'd31, 32'h48D0};
        tbl[14] = '{4'hF, 0, 0, 0, 4'b1000, 32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 5'd1, 4'd1, 4'd15, 32'd0, 1, 5'd1, 32'd0};
        tbl[15] = '{4'h0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd3, 4'd7, 32'd0, 1, 5'd0, 32'd0};
        tbl[16] = '{4'h1, 0, 0, 0, 4'b0000, 32'd0, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0, 4'd0, 4'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0};

        // reset held with live inputs: register must stay clear
        drive(tbl[0]);
        step();
        chk("rst_aluR", ex_aluR, 32'd0);
        chk("rst_zero", {31'd0, ex_zero}, 32'd1);
        chk("rst_destR", {27'd0, ex_destR}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_inB", ex_inB, 32'd0);
        chk("rst_ctl", {28'd0, ex_wreg, ex_m2reg, ex_wmem, ex_branch}, 32'd0);
        chk("rst_tags", {24'd0, MEM_ins_type, MEM_ins_number}, 32'd0);
        rst = 1;

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v);
            step();
            chk($sformatf("v%0d_aluR", i), ex_aluR, v.e_alu);
            chk($sformatf("v%0d_zero", i), {31'd0, ex_zero}, {31'd0, v.e_zero});
            chk($sformatf("v%0d_destR", i), {27'd0, ex_destR}, {27'd0, v.e_dest});
            chk($sformatf("v%0d_pc", i), ex_pc, v.e_pc);
            chk($sformatf("v%0d_inB", i), ex_inB, v.inb);
            chk($sformatf("v%0d_ctl", i), {28'd0, ex_wreg, ex_m2reg, ex_wmem, ex_branch}, {28'd0, v.ctl});
            chk($sformatf("v%0d_tags", i), {24'd0, MEM_ins_type, MEM_ins_number}, {24'd0, v.ityp, v.inum});
        end

        // no combinational path: changing ID inputs between edges leaves outputs alone
        v = tbl[0];
        drive(v);
        step();
        v = tbl[13];
        drive(v);
        #2;
        chk("hold_aluR", ex_aluR, 32'd12);
        chk("hold_destR", {27'd0, ex_destR}, 32'd9);

        // async reset mid-cycle clears outputs without a clock edge
        #1 rst = 0;
        #1;
        chk("arst_aluR", ex_aluR, 32'd0);
        chk("arst_zero", {31'd0, ex_zero}, 32'd1);
        chk("arst_wreg", {31'd0, ex_wreg}, 32'd0);
        step();
        rst = 1;
        step();
        chk("rel_aluR", ex_aluR, 32'h12340000);

        // signed overflow boundaries with wreg requested
        v = '{4'h0, 0, 0, 0, 4'b1000, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 5'd0, 5'd4, 4'd1, 4'd1, 32'h80000000, 0, 5'd4, 32'd0};
        drive(v);
        step();
        chk("ovfadd_aluR", ex_aluR, 32'h80000000);
`ifdef EX_OVF_EN
        chk("ovfadd_ovf", {31'd0, ex_ovf}, 32'd1);
        chk("ovfadd_wreg", {31'd0, ex_wreg}, 32'd0);
`else
        chk("ovfadd_wreg", {31'd0, ex_wreg}, 32'd1);
`endif
        v.aluc = 4'h1; v.ina = 32'h80000000; v.inb = 32'd1;
        drive(v);
        step();
        chk("ovfsub_aluR", ex_aluR, 32'h7FFFFFFF);
`ifdef EX_OVF_EN
        chk("ovfsub_ovf", {31'd0, ex_ovf}, 32'd1);
        chk("ovfsub_wreg", {31'd0, ex_wreg}, 32'd0);
`else
        chk("ovfsub_wreg", {31'd0, ex_wreg}, 32'd1);
`endif
        v.aluc = 4'h0; v.ina = 32'd1; v.inb = 32'd1;
        drive(v);
        step();
        chk("noovf_aluR", ex_aluR, 32'd2);
        chk("noovf_wreg", {31'd0, ex_wreg}, 32'd1);
`ifdef EX_OVF_EN
        chk("noovf_ovf", {31'd0, ex_ovf}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
